register_file: RTL and testbench
================================

Name: register_file

Overview:
Architectural register file with per-register rename tags. It sits between the Dispatcher and the reorder buffer's commit output. The Dispatcher reads rs1/rs2 values or dependency tags and renames rd to a new RoB index. The RoB commit port writes results and clears the rename when the committing index still owns the register. Flush clears all renames and keeps the committed values.

Parameters:
RoB_WIDTH, 3, width of a RoB index and of each rename tag
REG_NUM, 32, number of architectural registers (x0 hardwired to zero)

Ports:
clk_in  input  1  clock
rst_in  input  1  asynchronous active-high reset
rdy_in  input  1  global enable; low freezes all state
rs1_reg  input  5  Dispatcher read address 1
rs1_busy  output  1  rs1 value pending in RoB
rs1_tag  output  RoB_WIDTH  RoB index producing rs1 (valid when rs1_busy)
rs1_data  output  32  rs1 value (valid when !rs1_busy)
rs2_reg  input  5  read address 2
rs2_busy  output  1  as rs1
rs2_tag  output  RoB_WIDTH  as rs1
rs2_data  output  32  as rs1
rename_en  input  1  Dispatcher issues an instruction with rd
rename_reg  input  5  rd being renamed
rename_index  input  RoB_WIDTH  RoB index allocated to that instruction
RF_update_en  input  1  RoB commit writes a register
RF_update_reg  input  5  committed rd
RF_update_index  input  RoB_WIDTH  RoB index of committing entry
RF_update_data  input  32  committed value
flush_signal  input  1  misprediction flush from RoB

Behaviour:
- State: data[0..31] (32b), busy[0..31], tag[0..31] (RoB_WIDTH).
- Async reset (rst_in high, no clock edge needed): all data=0, busy=0, tag=0.
- Read outputs are combinational and have no registered outputs. During reset they therefore read 0 / not busy.
- Read rule, for each port p:
  - If p_reg==0: busy=0, data=0, tag=0.
  - Else if busy[r] and RF_update_en and RF_update_reg==r and RF_update_index==tag[r]: bypass. Output busy=0, data=RF_update_data.
  - Else: busy=busy[r], tag=tag[r], data=data[r].
  - The same-cycle rename is NOT visible to reads. The Dispatcher reads before renaming its own rd, so `add x1,x1,x2` depends on the older x1 producer.
- Commit, on posedge when rdy_in=1 and RF_update_en and RF_update_reg!=0:
  - data[reg] <= RF_update_data.
  - busy[reg] <= 0 only if busy[reg] and tag[reg]==RF_update_index, and no rename of the same reg in this cycle.
- Rename, on posedge when rdy_in=1, rename_en, rename_reg!=0, and !flush_signal: busy<=1 and tag<=rename_index. Rename wins over a commit clear on the same reg.
- Flush, on posedge when rdy_in=1 and flush_signal=1:
  - All busy<=0.
  - A commit in the same cycle still writes data, because the committing instruction is older than the flush point.
  - Rename is ignored.
  - flush_signal may stay high for 2 cycles; each cycle behaves identically.
- rdy_in=0: no state changes; reads stay live.
- x0: never written, never busy, regardless of inputs.
- Tag width wraps naturally. No comparison assumes ordering of indices.

Decomposition:
- Shared package (or header of localparams): RoB_WIDTH and REG_NUM.
- No sub-module. The two read ports are identical logic, written once as a function or generate loop.

Test Plan:
- Reset then read x5 -> busy=0, data=0. Commit x5=0x1234 with index 2 while x5 not busy -> next cycle data=0x1234, busy=0.
- Rename x3 to index 4. Read x3 next cycle -> busy=1, tag=4. Commit x3 index 4 data 0xAA -> same-cycle read shows busy=0, data=0xAA (bypass). Next cycle busy=0, data=0xAA.
- Rename x3 to index 1, then x3 to index 5. Commit x3 index 1 data 7 -> data[3]=7 but busy stays 1, tag=5. Same-cycle read gives busy=1, tag=5 (no bypass).
- Same cycle: commit x6 index 2 (x6 tag 2) and rename x6 to index 3 -> busy=1, tag=3, data=commit value.
- Rename x1..x4 to indices 0..3, then flush_signal=1 with commit x2 index 1 data 9 -> all busy=0, data[2]=9. A rename issued during the flush cycle is dropped.
- Rename x0 and commit x0=0xFFFF -> reads of x0 give 0, not busy. With rdy_in=0, rename x7 -> no change. Assert rst_in mid-run, without a clock edge -> outputs read 0 immediately.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared sizing and types for the architectural register file.
//   RoB_WIDTH  : width of a reorder-buffer index / rename tag
//   REG_NUM    : number of architectural registers (x0 hardwired to zero)
//   REG_ADDR_W : width of a register address
//   rd_port_t  : bundle returned by one read port (busy, tag, data)
package register_file_pkg;

   localparam int RoB_WIDTH  = 3;
   localparam int REG_NUM    = 32;
   localparam int REG_ADDR_W = $clog2(REG_NUM);
   localparam int DATA_W     = 32;

   typedef struct packed {
      logic                 busy;
      logic [RoB_WIDTH-1:0] tag;
      logic [DATA_W-1:0]    data;
   } rd_port_t;

endpackage

// File: rtl/register_file.sv
// Architectural register file with per-register rename tags.
// Sits between the Dispatcher (reads + rename of rd) and the reorder
// buffer commit port (writes + rename clear). A flush drops every rename
// but keeps committed values.
//
// Ports:
//   clk_in, rst_in (async, active high), rdy_in (global enable)
//   rs1_reg/rs2_reg            : read addresses
//   rsN_busy/rsN_tag/rsN_data  : combinational read results
//   rename_en/reg/index        : Dispatcher renames rd to a RoB index
//   RF_update_en/reg/index/data: RoB commit
//   flush_signal               : misprediction flush
module register_file
   import register_file_pkg::*;
(
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rdy_in,

   input  logic [REG_ADDR_W-1:0] rs1_reg,
   output logic                  rs1_busy,
   output logic [RoB_WIDTH-1:0]  rs1_tag,
   output logic [DATA_W-1:0]     rs1_data,

   input  logic [REG_ADDR_W-1:0] rs2_reg,
   output logic                  rs2_busy,
   output logic [RoB_WIDTH-1:0]  rs2_tag,
   output logic [DATA_W-1:0]     rs2_data,

   input  logic                  rename_en,
   input  logic [REG_ADDR_W-1:0] rename_reg,
   input  logic [RoB_WIDTH-1:0]  rename_index,

   input  logic                  RF_update_en,
   input  logic [REG_ADDR_W-1:0] RF_update_reg,
   input  logic [RoB_WIDTH-1:0]  RF_update_index,
   input  logic [DATA_W-1:0]     RF_update_data,

   input  logic                  flush_signal
);

   logic [DATA_W-1:0]    data_q [REG_NUM];
   logic                 busy_q [REG_NUM];
   logic [RoB_WIDTH-1:0] tag_q  [REG_NUM];

   logic commit_act;
   logic rename_act;

   assign commit_act = rdy_in && RF_update_en && (RF_update_reg != '0);
   assign rename_act = rdy_in && rename_en && (rename_reg != '0) && !flush_signal;

   // Index 0 is never written after reset, so x0 stays zero / not busy.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 0; i < REG_NUM; i++) begin
            data_q[i] <= '0;
            busy_q[i] <= 1'b0;
            tag_q[i]  <= '0;
         end
      end else if (rdy_in) begin
         for (int i = 1; i < REG_NUM; i++) begin
            if (commit_act && RF_update_reg == REG_ADDR_W'(i))
               data_q[i] <= RF_update_data;

            // Flush beats everything; a live rename beats a commit clear
            // because the newer producer now owns the register.
            if (flush_signal) begin
               busy_q[i] <= 1'b0;
            end else if (rename_act && rename_reg == REG_ADDR_W'(i)) begin
               busy_q[i] <= 1'b1;
               tag_q[i]  <= rename_index;
            end else if (commit_act && RF_update_reg == REG_ADDR_W'(i) &&
                         busy_q[i] && tag_q[i] == RF_update_index) begin
               busy_q[i] <= 1'b0;
            end
         end
      end
   end

   // One read port. A commit from the current owner is forwarded so the
   // Dispatcher does not wait a cycle for a value already on the bus.
   // Same-cycle renames are deliberately invisible here.
   function automatic rd_port_t read_port(input logic [REG_ADDR_W-1:0] r);
      rd_port_t res;
      res.busy = 1'b0;
      res.tag  = '0;
      res.data = '0;
      if (r != '0) begin
         res.tag = tag_q[r];
         if (busy_q[r] && RF_update_en && RF_update_reg == r &&
             RF_update_index == tag_q[r]) begin
            res.busy = 1'b0;
            res.data = RF_update_data;
         end else begin
            res.busy = busy_q[r];
            res.data = data_q[r];
         end
      end
      return res;
   endfunction

   rd_port_t rd1, rd2;

   always_comb begin
      rd1 = read_port(rs1_reg);
      rd2 = read_port(rs2_reg);
   end

   assign rs1_busy = rd1.busy;
   assign rs1_tag  = rd1.tag;
   assign rs1_data = rd1.data;
   assign rs2_busy = rd2.busy;
   assign rs2_tag  = rd2.tag;
   assign rs2_data = rd2.data;

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;
   import register_file_pkg::*;

   logic                  clk_in = 1'b0;
   logic                  rst_in;
   logic                  rdy_in;
   logic [REG_ADDR_W-1:0] rs1_reg, rs2_reg;
   logic                  rs1_busy, rs2_busy;
   logic [RoB_WIDTH-1:0]  rs1_tag, rs2_tag;
   logic [DATA_W-1:0]     rs1_data, rs2_data;
   logic                  rename_en;
   logic [REG_ADDR_W-1:0] rename_reg;
   logic [RoB_WIDTH-1:0]  rename_index;
   logic                  RF_update_en;
   logic [REG_ADDR_W-1:0] RF_update_reg;
   logic [RoB_WIDTH-1:0]  RF_update_index;
   logic [DATA_W-1:0]     RF_update_data;
   logic                  flush_signal;

   register_file dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .rs1_reg(rs1_reg), .rs1_busy(rs1_busy), .rs1_tag(rs1_tag), .rs1_data(rs1_data),
      .rs2_reg(rs2_reg), .rs2_busy(rs2_busy), .rs2_tag(rs2_tag), .rs2_data(rs2_data),
      .rename_en(rename_en), .rename_reg(rename_reg), .rename_index(rename_index),
      .RF_update_en(RF_update_en), .RF_update_reg(RF_update_reg),
      .RF_update_index(RF_update_index), .RF_update_data(RF_update_data),
      .flush_signal(flush_signal)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic                  rdy;
      logic                  ren;
      logic [REG_ADDR_W-1:0] rreg;
      logic [RoB_WIDTH-1:0]  ridx;
      logic                  uen;
      logic [REG_ADDR_W-1:0] ureg;
      logic [RoB_WIDTH-1:0]  uidx;
      logic [DATA_W-1:0]     udata;
      logic                  fl;
      logic [REG_ADDR_W-1:0] r1;
      logic [REG_ADDR_W-1:0] r2;
      logic                  e1b;
      logic [RoB_WIDTH-1:0]  e1t;
      logic [DATA_W-1:0]     e1d;
      logic                  e2b;
      logic [RoB_WIDTH-1:0]  e2t;
      logic [DATA_W-1:0]     e2d;
   } vec_t;

   vec_t vecs[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic vec_t mk(
      input logic rdy, input logic ren, input int rreg, input int ridx,
      input logic uen, input int ureg, input int uidx, input logic [31:0] udata,
      input logic fl, input int r1, input int r2,
      input logic e1b, input int e1t, input logic [31:0] e1d,
      input logic e2b, input int e2t, input logic [31:0] e2d);
      vec_t v;
      v.rdy = rdy; v.ren = ren; v.rreg = REG_ADDR_W'(rreg); v.ridx = RoB_WIDTH'(ridx);
      v.uen = uen; v.ureg = REG_ADDR_W'(ureg); v.uidx = RoB_WIDTH'(uidx); v.udata = udata;
      v.fl = fl; v.r1 = REG_ADDR_W'(r1); v.r2 = REG_ADDR_W'(r2);
      v.e1b = e1b; v.e1t = RoB_WIDTH'(e1t); v.e1d = e1d;
      v.e2b = e2b; v.e2t = RoB_WIDTH'(e2t); v.e2d = e2d;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Busy is always checked; tag only matters when busy, data only when not.
   task automatic check_port(input string name, input logic b, input logic [RoB_WIDTH-1:0] t,
                             input logic [31:0] d, input logic eb,
                             input logic [RoB_WIDTH-1:0] et, input logic [31:0] ed);
      check({name, ".busy"}, 32'(b), 32'(eb));
      if (eb) check({name, ".tag"}, 32'(t), 32'(et));
      else    check({name, ".data"}, d, ed);
   endtask

   task automatic idle_inputs();
      rdy_in = 1'b1; rename_en = 1'b0; rename_reg = '0; rename_index = '0;
      RF_update_en = 1'b0; RF_update_reg = '0; RF_update_index = '0;
      RF_update_data = '0; flush_signal = 1'b0;
   endtask

   initial begin
      //        rdy ren rr ri  uen ur ui data          fl r1 r2  e1b e1t e1d           e2b e2t e2d
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h0,      0, 5, 0,  0, 0, 32'h0,      0, 0, 32'h0));
      vecs.push_back(mk(1, 0, 0, 0, 1, 5, 2, 32'h1234,   0, 5, 5,  0, 0, 32'h0,      0, 0, 32'h0));
      vecs.push_back(mk(1, 1, 3, 4, 0, 0, 0, 32'h0,      0, 5, 3,  0, 0, 32'h1234,   0, 0, 32'h0));
      vecs.push_back(mk(1, 0, 0, 0, 1, 3, 4, 32'hAA,     0, 3, 3,  0, 0, 32'hAA,     0, 0, 32'hAA));
      vecs.push_back(mk(1, 1, 3, 1, 0, 0, 0, 32'h0,      0, 3, 5,  0, 0, 32'hAA,     0, 0, 32'h1234));
      vecs.push_back(mk(1, 1, 3, 5, 0, 0, 0, 32'h0,      0, 3, 0,  1, 1, 32'h0,      0, 0, 32'h0));
      vecs.push_back(mk(1, 0, 0, 0, 1, 3, 1, 32'h7,      0, 3, 3,  1, 5, 32'h0,      1, 5, 32'h0));
      vecs.push_back(mk(1, 1, 6, 2, 0, 0, 0, 32'h0,      0, 3, 0,  1, 5, 32'h0,      0, 0, 32'h0));
      vecs.push_back(mk(1, 1, 6, 3, 1, 6, 2, 32'h66,     0, 6, 3,  0, 0, 32'h66,     1, 5, 32'h0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h0,      0, 6, 3,  1, 3, 32'h0,      1, 5, 32'h0));
      vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 32'h0,      0, 1, 0,  0, 0, 32'h0,      0, 0, 32'h0));
      vecs.push_back(mk(1, 1, 2, 1, 0, 0, 0, 32'h0,      0, 1, 0,  1, 0, 32'h0,      0, 0, 32'h0));
      vecs.push_back(mk(1, 1, 3, 2, 0, 0, 0, 32'h0,      0, 2, 0,  1, 1, 32'h0,      0, 0, 32'h0));
      vecs.push_back(mk(1, 1, 4, 3, 0, 0, 0, 32'h0,      0, 2, 1,  1, 1, 32'h0,      1, 0, 32'h0));
      vecs.push_back(mk(1, 1, 7, 6, 1, 2, 1, 32'h9,      1, 2, 4,  0, 0, 32'h9,      1, 3, 32'h0));
      vecs.push_back(mk(1, 1, 7, 6, 0, 0, 0, 32'h0,      1, 7, 2,  0, 0, 32'h0,      0, 0, 32'h9));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h0,      0, 3, 6,  0, 0, 32'h7,      0, 0, 32'h66));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h0,      0, 1, 4,  0, 0, 32'h0,      0, 0, 32'h0));
      vecs.push_back(mk(1, 1, 0, 5, 1, 0, 0, 32'hFFFF,   0, 0, 0,  0, 0, 32'h0,      0, 0, 32'h0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h0,      0, 0, 7,  0, 0, 32'h0,      0, 0, 32'h0));
      vecs.push_back(mk(0, 1, 7, 6, 1, 5, 0, 32'hDEAD,   0, 7, 5,  0, 0, 32'h0,      0, 0, 32'h1234));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h0,      0, 7, 5,  0, 0, 32'h0,      0, 0, 32'h1234));
      vecs.push_back(mk(1, 1, 8, 7, 0, 0, 0, 32'h0,      0, 8, 0,  0, 0, 32'h0,      0, 0, 32'h0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0,      1, 8, 0,  1, 7, 32'h0,      0, 0, 32'h0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h0,      0, 8, 5,  1, 7, 32'h0,      0, 0, 32'h1234));

      rst_in = 1'b1;
      idle_inputs();
      rs1_reg = 5'd5; rs2_reg = 5'd9;
      #1;
      check_port("reset.rs1", rs1_busy, rs1_tag, rs1_data, 1'b0, '0, 32'h0);
      check("reset.rs2_tag", 32'(rs2_tag), 32'h0);
      @(negedge clk_in);
      @(negedge clk_in);
      rst_in = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk_in);
         rdy_in = vecs[i].rdy;
         rename_en = vecs[i].ren; rename_reg = vecs[i].rreg; rename_index = vecs[i].ridx;
         RF_update_en = vecs[i].uen; RF_update_reg = vecs[i].ureg;
         RF_update_index = vecs[i].uidx; RF_update_data = vecs[i].udata;
         flush_signal = vecs[i].fl;
         rs1_reg = vecs[i].r1; rs2_reg = vecs[i].r2;
         #1;
         check_port($sformatf("v%0d.rs1", i), rs1_busy, rs1_tag, rs1_data,
                    vecs[i].e1b, vecs[i].e1t, vecs[i].e1d);
         check_port($sformatf("v%0d.rs2", i), rs2_busy, rs2_tag, rs2_data,
                    vecs[i].e2b, vecs[i].e2t, vecs[i].e2d);
      end

      // Async reset between clock edges: x5 holds 0x1234, x8 is busy.
      @(negedge clk_in);
      idle_inputs();
      rs1_reg = 5'd5; rs2_reg = 5'd8;
      #1;
      check("pre_rst.rs1_data", rs1_data, 32'h1234);
      check("pre_rst.rs2_busy", 32'(rs2_busy), 32'h1);
      #1;
      rst_in = 1'b1;
      #1;
      check_port("async_rst.rs1", rs1_busy, rs1_tag, rs1_data, 1'b0, '0, 32'h0);
      check_port("async_rst.rs2", rs2_busy, rs2_tag, rs2_data, 1'b0, '0, 32'h0);
      check("async_rst.rs2_tag", 32'(rs2_tag), 32'h0);
      @(negedge clk_in);
      rst_in = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
